// File: rtl/decode_regread_stage.sv
// ---------------------------------------------------------------------------
// decode_regread_stage
//
// Decode / register-read pipeline stage. Pulls three register-number fields
// out of the incoming instruction, selects two read numbers, reads a
// 2**RN-entry register file and latches instruction, read numbers and
// operands into the ID/EX output register.
//
// Ports:
//   clock, reset              - sole rising-edge clock, synchronous active-high reset
//   in_valid, im_instr        - instruction from fetch and its valid flag
//   mux_rf_rn1_select         - port-1 number: 1 -> n1, 0 -> n2
//   mux_rf_rn2_select         - port-2 number: 1 -> n2, 0 -> n3
//   rf_w, dest, rf_wd         - register-file write port from writeback
//   stall, flush              - hold / invalidate the output latch (flush wins)
//   out_valid, out_instr      - latched instruction and valid
//   out_rn1, out_rn2          - latched read-port numbers
//   rf_rd1, rf_rd2            - latched operands
//
// A same-cycle write is forwarded into a load (bypass) and into a held
// latch whose stored register number matches (refresh), so operands sitting
// in the latch during a stall never go stale.
// ---------------------------------------------------------------------------
module decode_regread_stage #(
    parameter int DW = 16,
    parameter int RN = 2,
    parameter int IW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [IW-1:0] im_instr,
    input  logic          mux_rf_rn1_select,
    input  logic          mux_rf_rn2_select,
    input  logic          rf_w,
    input  logic [RN-1:0] dest,
    input  logic [DW-1:0] rf_wd,
    input  logic          stall,
    input  logic          flush,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [RN-1:0] out_rn1,
    output logic [RN-1:0] out_rn2,
    output logic [DW-1:0] rf_rd1,
    output logic [DW-1:0] rf_rd2
);

    localparam int NREG = 2 ** RN;

    // ---------------- instruction fields and read numbers ----------------
    logic [RN-1:0] n1, n2, n3;
    logic [RN-1:0] rn1, rn2;

    assign n1  = im_instr[IW-7 -: RN];
    assign n2  = im_instr[IW-7-RN -: RN];
    assign n3  = im_instr[IW-7-2*RN -: RN];
    assign rn1 = mux_rf_rn1_select ? n1 : n2;
    assign rn2 = mux_rf_rn2_select ? n2 : n3;

    // ---------------- register file ----------------
    // Reset must clear every entry, so the file is built from flops rather
    // than a RAM macro.
    logic [DW-1:0]   rf_q [NREG];
    logic [NREG-1:0] rf_we;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_we
            assign rf_we[gi] = rf_w && (dest == RN'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREG; i++) begin
            if (reset) begin
                rf_q[i] <= '0;
            end else if (rf_we[i]) begin
                rf_q[i] <= rf_wd;
            end
        end
    end

    // Write-through bypass: each port independently sees this cycle's write.
    logic [DW-1:0] rd1_byp, rd2_byp;
    assign rd1_byp = (rf_w && dest == rn1) ? rf_wd : rf_q[rn1];
    assign rd2_byp = (rf_w && dest == rn2) ? rf_wd : rf_q[rn2];

    // ---------------- output latch ----------------
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_instr_q, out_instr_d;
    logic [RN-1:0] out_rn1_q,   out_rn1_d;
    logic [RN-1:0] out_rn2_q,   out_rn2_d;
    logic [DW-1:0] rf_rd1_q,    rf_rd1_d;
    logic [DW-1:0] rf_rd2_q,    rf_rd2_d;

    always_comb begin
        // Default is "hold with refresh": shared by stall and flush, since a
        // flushed latch keeps its data fields and they must stay current too.
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_rn1_d   = out_rn1_q;
        out_rn2_d   = out_rn2_q;
        rf_rd1_d    = (rf_w && dest == out_rn1_q) ? rf_wd : rf_rd1_q;
        rf_rd2_d    = (rf_w && dest == out_rn2_q) ? rf_wd : rf_rd2_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (!stall) begin
            // Load captures unconditionally; in_valid only sets the flag.
            out_valid_d = in_valid;
            out_instr_d = im_instr;
            out_rn1_d   = rn1;
            out_rn2_d   = rn2;
            rf_rd1_d    = rd1_byp;
            rf_rd2_d    = rd2_byp;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_rn1_q   <= '0;
            out_rn2_q   <= '0;
            rf_rd1_q    <= '0;
            rf_rd2_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_rn1_q   <= out_rn1_d;
            out_rn2_q   <= out_rn2_d;
            rf_rd1_q    <= rf_rd1_d;
            rf_rd2_q    <= rf_rd2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_rn1   = out_rn1_q;
    assign out_rn2   = out_rn2_q;
    assign rf_rd1    = rf_rd1_q;
    assign rf_rd2    = rf_rd2_q;

endmodule

// File: tb/tb_decode_regread_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_regread_stage
//
// Directed vector table for the default configuration, a short sequence on
// a wide (RN=3, DW=32, IW=24) instance, then randomized cycles compared
// against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_decode_regread_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- default instance ----------------
    logic        reset, in_valid, sel1, sel2, rf_w, stall, flush;
    logic [15:0] im_instr, rf_wd;
    logic [1:0]  dest;
    logic        out_valid;
    logic [15:0] out_instr, rf_rd1, rf_rd2;
    logic [1:0]  out_rn1, out_rn2;

    decode_regread_stage #(.DW(16), .RN(2), .IW(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .im_instr(im_instr),
        .mux_rf_rn1_select(sel1), .mux_rf_rn2_select(sel2),
        .rf_w(rf_w), .dest(dest), .rf_wd(rf_wd), .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_instr(out_instr), .out_rn1(out_rn1),
        .out_rn2(out_rn2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
    );

    // ---------------- wide instance ----------------
    logic        w_reset, w_in_valid, w_sel1, w_sel2, w_rf_w, w_stall, w_flush;
    logic [23:0] w_instr;
    logic [31:0] w_wd;
    logic [2:0]  w_dest;
    logic        w_out_valid;
    logic [23:0] w_out_instr;
    logic [2:0]  w_out_rn1, w_out_rn2;
    logic [31:0] w_rd1, w_rd2;

    decode_regread_stage #(.DW(32), .RN(3), .IW(24)) dut_w (
        .clock(clock), .reset(w_reset), .in_valid(w_in_valid), .im_instr(w_instr),
        .mux_rf_rn1_select(w_sel1), .mux_rf_rn2_select(w_sel2),
        .rf_w(w_rf_w), .dest(w_dest), .rf_wd(w_wd), .stall(w_stall), .flush(w_flush),
        .out_valid(w_out_valid), .out_instr(w_out_instr), .out_rn1(w_out_rn1),
        .out_rn2(w_out_rn2), .rf_rd1(w_rd1), .rf_rd2(w_rd2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, iv;
        logic [15:0] instr;
        logic        s1, s2, w;
        logic [1:0]  d;
        logic [15:0] wd;
        logic        st, fl;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [1:0]  e_rn1, e_rn2;
        logic [15:0] e_rd1, e_rd2;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic iv, input logic [15:0] instr,
                       input logic s1, input logic s2, input logic w, input logic [1:0] d,
                       input logic [15:0] wd, input logic st, input logic fl,
                       input logic ev, input logic [15:0] ei, input logic [1:0] er1,
                       input logic [1:0] er2, input logic [15:0] ed1, input logic [15:0] ed2);
        vec_t v;
        v.rst = rst; v.iv = iv; v.instr = instr; v.s1 = s1; v.s2 = s2;
        v.w = w; v.d = d; v.wd = wd; v.st = st; v.fl = fl;
        v.e_valid = ev; v.e_instr = ei; v.e_rn1 = er1; v.e_rn2 = er2;
        v.e_rd1 = ed1; v.e_rd2 = ed2;
        vq.push_back(v);
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [4];
    logic        m_valid;
    logic [15:0] m_instr, m_rd1, m_rd2;
    logic [1:0]  m_rn1, m_rn2;

    function automatic logic [15:0] m_read(input int n);
        if (rf_w && int'(dest) == n) return rf_wd;
        return m_regs[n];
    endfunction

    // Next outputs from the current inputs; call before the clock edge.
    task automatic model_step();
        int f1, f2, f3, r1, r2;
        f1 = (int'(im_instr) / 256) % 4;   // bits 9:8
        f2 = (int'(im_instr) / 64) % 4;    // bits 7:6
        f3 = (int'(im_instr) / 16) % 4;    // bits 5:4
        r1 = sel1 ? f1 : f2;
        r2 = sel2 ? f2 : f3;
        if (reset) begin
            m_valid = 0; m_instr = 0; m_rn1 = 0; m_rn2 = 0; m_rd1 = 0; m_rd2 = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            return;
        end
        if (flush || stall) begin
            if (flush) m_valid = 0;
            if (rf_w && dest == m_rn1) m_rd1 = rf_wd;
            if (rf_w && dest == m_rn2) m_rd2 = rf_wd;
        end else begin
            m_valid = in_valid;
            m_instr = im_instr;
            m_rn1   = 2'(r1);
            m_rn2   = 2'(r2);
            m_rd1   = m_read(r1);
            m_rd2   = m_read(r2);
        end
        if (rf_w) m_regs[dest] = rf_wd;
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [15:0] instr,
                         input logic s1, input logic s2, input logic w, input logic [1:0] d,
                         input logic [15:0] wd, input logic st, input logic fl);
        reset = rst; in_valid = iv; im_instr = instr; sel1 = s1; sel2 = s2;
        rf_w = w; dest = d; rf_wd = wd; stall = st; flush = fl;
    endtask

    initial begin
        drive(0, 0, 16'h0, 0, 0, 0, 2'd0, 16'h0, 0, 0);
        w_reset = 1; w_in_valid = 0; w_instr = '0; w_sel1 = 0; w_sel2 = 0;
        w_rf_w = 0; w_dest = '0; w_wd = '0; w_stall = 0; w_flush = 0;

        //   rst iv instr    s1 s2 w  d  wd        st fl | v  instr    rn1 rn2 rd1       rd2
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 1, 1, 16'h1234, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0140, 1, 1, 0, 0, 16'h0000, 0, 0,   1, 16'h0140, 1, 1, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 1, 2, 16'hAAAA, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 1, 3, 16'h5555, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0230, 1, 0, 0, 0, 16'h0000, 0, 0,   1, 16'h0230, 2, 3, 16'hAAAA, 16'h5555);
        add(0, 1, 16'h0280, 1, 1, 1, 2, 16'hBEEF, 0, 0,   1, 16'h0280, 2, 2, 16'hBEEF, 16'hBEEF);
        add(0, 0, 16'h0280, 1, 1, 0, 0, 16'h0000, 0, 0,   0, 16'h0280, 2, 2, 16'hBEEF, 16'hBEEF);
        add(0, 1, 16'h0320, 1, 0, 0, 0, 16'h0000, 0, 0,   1, 16'h0320, 3, 2, 16'h5555, 16'hBEEF);
        add(0, 0, 16'hFFFF, 0, 0, 1, 3, 16'h0F0F, 1, 0,   1, 16'h0320, 3, 2, 16'h0F0F, 16'hBEEF);
        add(0, 0, 16'hFFFF, 0, 0, 1, 2, 16'h1111, 1, 0,   1, 16'h0320, 3, 2, 16'h0F0F, 16'h1111);
        add(0, 1, 16'h01C0, 0, 1, 0, 0, 16'h0000, 0, 0,   1, 16'h01C0, 3, 3, 16'h0F0F, 16'h0F0F);
        add(0, 1, 16'hFFFF, 1, 1, 1, 3, 16'h2222, 1, 1,   0, 16'h01C0, 3, 3, 16'h2222, 16'h2222);
        add(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 1, 0, 16'h7777, 0, 0,   0, 16'h0000, 0, 0, 16'h7777, 16'h7777);
        add(0, 1, 16'h0140, 1, 1, 0, 0, 16'h0000, 0, 1,   0, 16'h0000, 0, 0, 16'h7777, 16'h7777);
        add(1, 1, 16'h0140, 1, 1, 1, 0, 16'h9999, 1, 0,   0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0,   1, 16'h0000, 0, 0, 16'h0000, 16'h0000);

        @(posedge clock);
        #1;
        foreach (vq[i]) begin
            int e0;
            e0 = errors;
            drive(vq[i].rst, vq[i].iv, vq[i].instr, vq[i].s1, vq[i].s2,
                  vq[i].w, vq[i].d, vq[i].wd, vq[i].st, vq[i].fl);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].e_valid));
            check($sformatf("vec%0d out_instr", i), 32'(out_instr), 32'(vq[i].e_instr));
            check($sformatf("vec%0d out_rn1", i),   32'(out_rn1),   32'(vq[i].e_rn1));
            check($sformatf("vec%0d out_rn2", i),   32'(out_rn2),   32'(vq[i].e_rn2));
            check($sformatf("vec%0d rf_rd1", i),    32'(rf_rd1),    32'(vq[i].e_rd1));
            check($sformatf("vec%0d rf_rd2", i),    32'(rf_rd2),    32'(vq[i].e_rd2));
            $display("vec %0d instr=%h valid=%b rd1=%h rd2=%h %s", i, out_instr, out_valid,
                     rf_rd1, rf_rd2, (errors == e0) ? "ok" : "bad");
        end

        // ---------------- wide configuration sequence ----------------
        // Cycle 1 (reset active), cycle 2: write r7, cycle 3: read rn1=7 from storage.
        @(posedge clock);
        #1;
        w_reset = 0; w_rf_w = 1; w_dest = 3'd7; w_wd = 32'hDEADBEEF;
        @(posedge clock);
        #1;
        w_rf_w = 0; w_in_valid = 1; w_instr = 24'h038000; w_sel1 = 1; w_sel2 = 0;
        @(posedge clock);
        #1;
        check("wide rf_rd1", w_rd1, 32'hDEADBEEF);
        check("wide out_rn1", 32'(w_out_rn1), 32'd7);
        check("wide rf_rd2", w_rd2, 32'h0);
        check("wide out_valid", 32'(w_out_valid), 32'd1);
        $display("wide instr=%h rn1=%0d rd1=%h", w_out_instr, w_out_rn1, w_rd1);
        // Bypass on the wide instance: rn2 = n3 = bits[11:9] = 5, written this cycle.
        w_instr = 24'h000A00; w_sel1 = 0; w_sel2 = 0;
        w_rf_w = 1; w_dest = 3'd5; w_wd = 32'h01234567;
        @(posedge clock);
        #1;
        w_rf_w = 0;
        check("wide bypass rd2", w_rd2, 32'h01234567);
        check("wide bypass rn2", 32'(w_out_rn2), 32'd5);
        $display("wide instr=%h rn2=%0d rd2=%h", w_out_instr, w_out_rn2, w_rd2);

        // ---------------- randomized against the model ----------------
        drive(1, 0, 16'h0, 0, 0, 0, 2'd0, 16'h0, 0, 0);
        model_step();
        @(posedge clock);
        #1;
        for (int c = 0; c < 400; c++) begin
            int e0;
            e0 = errors;
            drive(($urandom_range(0, 39) == 0), 1'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                  16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            model_step();
            @(posedge clock);
            #1;
            check("rand out_valid", 32'(out_valid), 32'(m_valid));
            check("rand out_instr", 32'(out_instr), 32'(m_instr));
            check("rand out_rn1",   32'(out_rn1),   32'(m_rn1));
            check("rand out_rn2",   32'(out_rn2),   32'(m_rn2));
            check("rand rf_rd1",    32'(rf_rd1),    32'(m_rd1));
            check("rand rf_rd2",    32'(rf_rd2),    32'(m_rd2));
            $display("rand %0d rst=%b st=%b fl=%b w=%b instr=%h rd1=%h rd2=%h %s", c, reset,
                     stall, flush, rf_w, out_instr, rf_rd1, rf_rd2, (errors == e0) ? "ok" : "bad");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
